// File: rtl/clock_period_meter_pkg.sv
// Shared types and defaults for the clock period meter.
// FSM encoding, default sizing and the per-cycle control strobes.
package clock_period_meter_pkg;

    localparam int unsigned DEF_WIDTH   = 28;
    localparam int unsigned DEF_TIMEOUT = 100_000_000;

    typedef enum logic [1:0] {
        ARM     = 2'd0,
        MEASURE = 2'd1,
        LOST    = 2'd2
    } state_t;

    typedef struct packed {
        logic load_result;
        logic latch_high;
        logic set_timeout;
        logic clr_timeout;
    } ctrl_t;

endpackage

// File: rtl/clock_period_meter_signal_edge_sync.sv
// Two-flop synchronizer plus history flop for a slow asynchronous input.
// Rise/fall are single-cycle strobes two clocks after the input is sampled.
module signal_edge_sync
    import clock_period_meter_pkg::*;
(
    input  logic clock_in,
    input  logic reset_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;
    assign fall  = ~s2 & s3;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous signal in clock_in
// cycles; results leave over valid/ready, loss of signal raises timeout.
module clock_period_meter
    import clock_period_meter_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             signal_in,
    input  logic             result_ready,
    output logic             result_valid,
    output logic [WIDTH-1:0] period_out,
    output logic [WIDTH-1:0] high_out,
    output logic             overrun,
    output logic             timeout
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic             rise;
    logic             fall;
    logic             level_unused;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] hi_cnt;
    logic             cnt_at_max;
    logic             accept;
    state_t           state;
    state_t           state_n;
    ctrl_t            ctrl;

    signal_edge_sync u_sync (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .async_in (signal_in),
        .level    (level_unused),
        .rise     (rise),
        .fall     (fall)
    );

    assign cnt_at_max = (cnt == CNT_MAX);
    assign accept     = result_valid & result_ready;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state <= ARM;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ARM: begin
                if (rise) begin
                    state_n = MEASURE;
                end
            end
            MEASURE: begin
                if (!rise && cnt_at_max) begin
                    state_n = LOST;
                end
            end
            LOST: begin
                if (rise) begin
                    state_n = ARM;
                end
            end
            default: begin
                state_n = ARM;
            end
        endcase
    end

    // Rise beats the timeout check when both land on the same cycle.
    always_comb begin
        ctrl = '0;
        unique case (state)
            MEASURE: begin
                ctrl.load_result = rise;
                ctrl.latch_high  = fall;
                ctrl.set_timeout = ~rise & cnt_at_max;
            end
            LOST: begin
                ctrl.clr_timeout = rise;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

    // Restarting at 1 makes a divide-by-N input read back as exactly N.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= CNT_ONE;
        end else if (!cnt_at_max) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            hi_cnt <= '0;
        end else if (ctrl.latch_high) begin
            hi_cnt <= cnt;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            result_valid <= 1'b0;
            period_out   <= '0;
            high_out     <= '0;
        end else if (ctrl.load_result) begin
            result_valid <= 1'b1;
            period_out   <= cnt;
            high_out     <= hi_cnt;
        end else if (accept) begin
            result_valid <= 1'b0;
        end
    end

    // Only an unaccepted result being replaced counts as an overrun.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (ctrl.load_result && result_valid && !result_ready) begin
            overrun <= 1'b1;
        end else if (accept) begin
            overrun <= 1'b0;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            timeout <= 1'b0;
        end else if (ctrl.set_timeout) begin
            timeout <= 1'b1;
        end else if (ctrl.clr_timeout) begin
            timeout <= 1'b0;
        end
    end

endmodule
